// File: rtl/axi_dac_jesd204_sync_ctrl_pkg.sv
// Shared encodings for the JESD204 DAC datapath sync sequencer.
package axi_dac_jesd204_sync_ctrl_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_LMFC = 3'd2,
    ST_SYNC      = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_DONE      = 3'd5
  } sync_state_e;

endpackage

// File: rtl/axi_dac_jesd204_sync_ctrl.sv
// Mutes the DAC, optionally aligns to LMFC, pulses per-channel datapath sync,
// then holds mute until the DDS pipeline has flushed.
module axi_dac_jesd204_sync_ctrl
  import axi_dac_jesd204_sync_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned SYNC_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    dac_clk,
  input  logic                    dac_rstn,
  input  logic                    sync_req,
  input  logic                    sync_ext_mode,
  input  logic                    dac_lmfc,
  input  logic [NUM_CHANNELS-1:0] chan_mask,
  output logic [NUM_CHANNELS-1:0] dac_data_sync,
  output logic                    dac_mute,
  output logic                    sync_busy,
  output logic                    sync_done,
  output logic                    sync_timeout,
  output logic [15:0]             sync_count
);

  localparam logic [CNT_W-1:0] SYNC_LOAD    = CNT_W'(SYNC_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  sync_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic                    mode_q, mode_d;
  logic                    pend_q, pend_d;
  logic                    tout_q, tout_d;
  logic [15:0]             count_q, count_d;
  logic [NUM_CHANNELS-1:0] dsync_q, dsync_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    tout_d  = tout_q;
    count_d = count_q;

    // Requests outside IDLE collapse into a single pending re-run.
    if (state_q != ST_IDLE && sync_req) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (sync_req) begin
          mask_d  = chan_mask;
          mode_d  = sync_ext_mode;
          tout_d  = 1'b0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (mode_q) begin
          state_d = ST_WAIT_LMFC;
          cnt_d   = TIMEOUT_LOAD;
        end else begin
          state_d = ST_SYNC;
          cnt_d   = SYNC_LOAD;
        end
      end
      ST_WAIT_LMFC: begin
        if (dac_lmfc) begin
          state_d = ST_SYNC;
          cnt_d   = SYNC_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
          tout_d  = 1'b1;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SYNC: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        // A request landing in DONE itself counts as pending too.
        if (pend_q || sync_req) begin
          mask_d  = chan_mask;
          mode_d  = sync_ext_mode;
          pend_d  = 1'b0;
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE) begin
      count_d = count_q + 16'd1;
    end

    dsync_d = (state_d == ST_SYNC) ? mask_q : '0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
      tout_q  <= 1'b0;
      count_q <= '0;
      dsync_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      tout_q  <= tout_d;
      count_q <= count_d;
      dsync_q <= dsync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dac_data_sync = dsync_q;
  assign dac_mute      = busy_q;
  assign sync_busy     = busy_q;
  assign sync_done     = done_q;
  assign sync_timeout  = tout_q;
  assign sync_count    = count_q;

endmodule

// File: tb/tb_axi_dac_jesd204_sync_ctrl.sv
// Bench for the DAC sync sequencer: scenario table, hand-built corner cases and
// a randomized run checked cycle by cycle against a frame-queue reference.
module tb_axi_dac_jesd204_sync_ctrl;

  localparam int unsigned NCH = 4;
  localparam int unsigned SC  = 2;
  localparam int unsigned ST  = 16;
  localparam int unsigned TO  = 12;

  logic           clk   = 1'b0;
  logic           rstn  = 1'b1;
  logic           req   = 1'b0;
  logic           mode  = 1'b0;
  logic           lmfc  = 1'b0;
  logic [NCH-1:0] mask  = '0;
  logic [NCH-1:0] dsync;
  logic           mute, busy, done, tout;
  logic [15:0]    cnt;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  axi_dac_jesd204_sync_ctrl #(
    .NUM_CHANNELS  (NCH),
    .SYNC_CYCLES   (SC),
    .SETTLE_CYCLES (ST),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .dac_clk      (clk),
    .dac_rstn     (rstn),
    .sync_req     (req),
    .sync_ext_mode(mode),
    .dac_lmfc     (lmfc),
    .chan_mask    (mask),
    .dac_data_sync(dsync),
    .dac_mute     (mute),
    .sync_busy    (busy),
    .sync_done    (done),
    .sync_timeout (tout),
    .sync_count   (cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: a queue of upcoming output frames, one per cycle; WAIT is a
  // single frame that stays at the head until LMFC or the timeout elapses.
  typedef struct packed {
    logic [NCH-1:0] sync;
    logic           done;
    logic           wt;
  } frame_t;

  frame_t         q[$];
  int unsigned    m_elapsed = 0;
  bit             m_pend    = 1'b0;
  bit             m_tout    = 1'b0;
  logic [15:0]    m_cnt     = '0;
  logic [NCH-1:0] m_mask    = '0;

  function automatic void push_tail();
    for (int unsigned i = 0; i < SC; i++) q.push_back('{sync: m_mask, done: 1'b0, wt: 1'b0});
    for (int unsigned i = 0; i < ST; i++) q.push_back('{sync: '0, done: 1'b0, wt: 1'b0});
    q.push_back('{sync: '0, done: 1'b1, wt: 1'b0});
  endfunction

  function automatic void accept(input logic [NCH-1:0] mk, input logic md);
    m_mask    = mk;
    m_elapsed = 0;
    q.push_back('{sync: '0, done: 1'b0, wt: 1'b0});
    if (md) q.push_back('{sync: '0, done: 1'b0, wt: 1'b1});
    else    push_tail();
  endfunction

  function automatic void model_step();
    frame_t cur;
    if (q.size() == 0) begin
      if (req) begin
        m_tout = 1'b0;
        accept(mask, mode);
      end
    end else begin
      cur = q[0];
      if (req) m_pend = 1'b1;
      if (cur.wt) begin
        if (lmfc) begin
          void'(q.pop_front());
          push_tail();
        end else begin
          m_elapsed++;
          if (m_elapsed == TO) begin
            void'(q.pop_front());
            m_tout = 1'b1;
            m_pend = 1'b0;
          end
        end
      end else begin
        void'(q.pop_front());
        if (cur.done && m_pend) begin
          m_pend = 1'b0;
          accept(mask, mode);
        end
      end
    end
    if (q.size() > 0 && q[0].done) m_cnt++;
  endfunction

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      q.delete();
      m_pend = 1'b0;
      m_tout = 1'b0;
      m_cnt  = '0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    logic [NCH-1:0] es;
    logic           eb, ed;
    @(negedge clk);
    if (chk_en) begin
      es = '0; eb = 1'b0; ed = 1'b0;
      if (q.size() > 0) begin
        es = q[0].sync; eb = 1'b1; ed = q[0].done;
      end
      check("cycle", 32'({dsync, mute, busy, done, tout, cnt}),
                     32'({es, eb, eb, ed, m_tout, m_cnt}));
    end
  end

  // One sequence, measured from the request edge until busy falls.
  task automatic run(input bit md, input logic [NCH-1:0] mk, input int l1, input int l2,
                     input int rq1, input int rq2, input logic [NCH-1:0] mk2,
                     output int start, output int slen, output int mute_n,
                     output int done_n, output logic [NCH-1:0] sval);
    start = -1; slen = 0; mute_n = 0; done_n = 0; sval = '0;
    req = 1'b1; mode = md; mask = mk;
    @(negedge clk);
    req = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (mute) mute_n++;
      if (done) done_n++;
      if (|dsync) begin
        if (start < 0) start = t;
        slen++;
        sval = dsync;
      end
      lmfc = (l1 > 0 && t == l1 - 1) || (l2 > 0 && t == l2 - 1);
      req  = (rq1 > 0 && t == rq1 - 1) || (rq2 > 0 && t == rq2 - 1);
      if (req) mask = mk2;
      if (!busy && t > 0) break;
      @(negedge clk);
    end
    lmfc = 1'b0;
    req  = 1'b0;
    check("budget", 32'(busy), 32'd0);
  endtask

  typedef struct {
    bit             mode;
    logic [NCH-1:0] mask;
    int             l1, l2, rq1, rq2;
    logic [NCH-1:0] mk2;
    int             e_start, e_slen, e_mute, e_done, e_inc;
    bit             e_tout;
  } row_t;

  row_t rows[$];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int             st, sl, mn, dn;
    logic [NCH-1:0] sv;
    logic [15:0]    c0;
    bit             prev_tout;

    //                mode mask    l1 l2  rq1 rq2 mk2     start slen mute done inc tout
    rows.push_back('{1'b0, 4'b0101, 0, 0,  0,  0, 4'b0000, 1,   2,   20,  1,   1,  1'b0});
    rows.push_back('{1'b1, 4'b1010, 0, 10, 0,  0, 4'b0000, 10,  2,   29,  1,   1,  1'b0});
    rows.push_back('{1'b1, 4'b0110, 1, 10, 0,  0, 4'b0000, 10,  2,   29,  1,   1,  1'b0});
    rows.push_back('{1'b1, 4'b0011, 0, 2,  0,  0, 4'b0000, 2,   2,   21,  1,   1,  1'b0});
    rows.push_back('{1'b1, 4'b1111, 0, 0,  0,  0, 4'b0000, -1,  0,   13,  0,   0,  1'b1});
    rows.push_back('{1'b0, 4'b1100, 0, 0,  0,  0, 4'b0000, 1,   2,   20,  1,   1,  1'b0});
    rows.push_back('{1'b1, 4'b0001, 0, 13, 0,  0, 4'b0000, 13,  2,   32,  1,   1,  1'b0});
    rows.push_back('{1'b0, 4'b0000, 0, 0,  0,  0, 4'b0000, -1,  0,   20,  1,   1,  1'b0});
    rows.push_back('{1'b1, 4'b1001, 1, 0,  0,  0, 4'b0000, -1,  0,   13,  0,   0,  1'b1});
    rows.push_back('{1'b0, 4'b0011, 0, 0,  6,  9, 4'b1000, 1,   4,   40,  2,   2,  1'b0});

    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({dsync, mute, busy, done, tout, cnt}), 32'd0);
    rstn   = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    prev_tout = 1'b0;
    foreach (rows[i]) begin
      c0 = cnt;
      run(rows[i].mode, rows[i].mask, rows[i].l1, rows[i].l2, rows[i].rq1, rows[i].rq2,
          rows[i].mk2, st, sl, mn, dn, sv);
      check($sformatf("row%0d_start", i), st, rows[i].e_start);
      check($sformatf("row%0d_slen", i), sl, rows[i].e_slen);
      check($sformatf("row%0d_mute", i), mn, rows[i].e_mute);
      check($sformatf("row%0d_done", i), dn, rows[i].e_done);
      check($sformatf("row%0d_inc", i), 32'(16'(cnt - c0)), rows[i].e_inc);
      check($sformatf("row%0d_tout", i), 32'(tout), 32'(rows[i].e_tout));
      if (rows[i].e_slen > 0)
        check($sformatf("row%0d_sval", i), 32'(sv), 32'(rows[i].rq1 > 0 ? rows[i].mk2 : rows[i].mask));
      if (prev_tout && !rows[i].e_tout)
        check($sformatf("row%0d_tout_clear", i), 32'(tout), 32'd0);
      prev_tout = rows[i].e_tout;
      repeat (2) @(negedge clk);
    end

    // Asynchronous reset in the middle of SYNC with a request pending.
    req = 1'b1; mode = 1'b0; mask = 4'hF;
    @(negedge clk);
    @(negedge clk);
    req = 1'b0;
    check("mid_sync", 32'(dsync), 32'hF);
    #2 rstn = 1'b0;
    #1 check("async_reset", 32'({dsync, mute, busy, done, tout, cnt}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    run(1'b0, 4'b0110, 0, 0, 0, 0, 4'b0000, st, sl, mn, dn, sv);
    check("post_reset_mute", mn, 20);
    check("post_reset_done", dn, 1);
    check("post_reset_count", 32'(cnt), 32'd1);
    repeat (2) @(negedge clk);

    // Counter wrap.
    chk_en = 1'b0;
    force dut.count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    chk_en = 1'b1;
    check("wrap_pre", 32'(cnt), 32'hFFFF);
    run(1'b0, 4'b0001, 0, 0, 0, 0, 4'b0000, st, sl, mn, dn, sv);
    check("wrap", 32'(cnt), 32'd0);
    repeat (2) @(negedge clk);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      req  = ($urandom_range(15) == 0);
      mode = 1'($urandom_range(1));
      mask = NCH'($urandom);
      lmfc = ($urandom_range(7) == 0);
      @(negedge clk);
    end
    req = 1'b0; lmfc = 1'b0;
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    check("drain", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_dac_jesd204_sync_ctrl.md
# axi_dac_jesd204_sync_ctrl

Sequencer for the per-channel DDS/PN datapath sync in the JESD204 DAC core. On a processor sync request it mutes the DAC output, optionally aligns to the next LMFC boundary, and pulses `dac_data_sync` to the selected channels. This resets their PN generators, DDS phase accumulators and DDS increments. It then holds the mute until the DDS pipeline has flushed. The block sits in the `dac_clk` domain between the register bank (request, mask, mode) and the channel instances.

## Interface
- `NUM_CHANNELS`, 4: number of channel sync outputs (1..16).
- `SYNC_CYCLES`, 2: width of the `dac_data_sync` pulse in cycles (1..15).
- `SETTLE_CYCLES`, 16: post-sync mute hold covering DDS pipeline latency (1..255).
- `TIMEOUT_CYCLES`, 4096: cycles allowed in the LMFC wait before abort (2..65535).

Ports:
- `dac_clk`  in  1  core clock; everything is sampled on its rising edge.
- `dac_rstn`  in  1  asynchronous, active-low reset.
- `sync_req`  in  1  one-cycle sync request, already in the `dac_clk` domain.
- `sync_ext_mode`  in  1  1 = wait for `dac_lmfc`; 0 = sync immediately. Sampled with `sync_req`.
- `dac_lmfc`  in  1  one-cycle LMFC boundary pulse from the link layer.
- `chan_mask`  in  `NUM_CHANNELS`  channels to sync. Sampled with `sync_req`.
- `dac_data_sync`  out  `NUM_CHANNELS`  per-channel sync level, equal to the captured mask ANDed with the SYNC state.
- `dac_mute`  out  1  high while a sequence is active; downstream forces the DAC data to zero.
- `sync_busy`  out  1  high while the FSM is not IDLE.
- `sync_done`  out  1  one-cycle pulse when a sequence completes.
- `sync_timeout`  out  1  sticky; set on LMFC-wait abort, cleared by the next accepted `sync_req`.
- `sync_count`  out  16  completed-sequence counter; wraps 0xFFFF -> 0.

## Operation
- States: IDLE, ARM, WAIT_LMFC, SYNC, SETTLE, DONE. A single 16-bit down-counter is shared by WAIT_LMFC, SYNC and SETTLE.
- IDLE: when `sync_req`=1, capture `chan_mask` and `sync_ext_mode`, clear `sync_timeout`, then go to ARM.
- ARM: lasts one cycle and gives a one-cycle mute lead.
  - Mode 1: go to WAIT_LMFC with the counter loaded to `TIMEOUT_CYCLES`-1.
  - Mode 0: go to SYNC with the counter loaded to `SYNC_CYCLES`-1.
- WAIT_LMFC:
  - If `dac_lmfc`=1, go to SYNC; this has priority over the counter reaching 0 in the same cycle.
  - Else if the counter is 0, set `sync_timeout` and go to IDLE. No sync is issued, no `sync_done` pulse, and `sync_count` is unchanged.
  - Otherwise decrement the counter.
- SYNC: `dac_data_sync` = captured mask. When the counter reaches 0, load `SETTLE_CYCLES`-1 and go to SETTLE.
- SETTLE: when the counter reaches 0, go to DONE.
- DONE: lasts one cycle. `sync_done`=1, `sync_count`+1, next state is IDLE.
- `dac_lmfc` is ignored outside WAIT_LMFC.
- A `sync_req` arriving in any state other than IDLE sets one pending flag; further requests are absorbed into it.
  - From DONE, a set pending flag takes the FSM to ARM instead of IDLE. Mask and mode are re-sampled from the inputs in that DONE cycle.
  - A timeout clears the pending flag.
- An all-zero captured mask still runs the full sequence: mute, done pulse and count increment all occur, with `dac_data_sync` held at 0.
- `dac_rstn` low, including mid-sequence, immediately forces:
  - state IDLE;
  - every output 0 (`dac_data_sync`, `dac_mute`, `sync_busy`, `sync_done`, `sync_timeout`, `sync_count`);
  - the pending flag 0.

## Timing
- All outputs are registered and decoded from the next-state, so each output changes at the same edge as the state.
- `sync_req` high at edge k: `sync_busy` and `dac_mute` go high after edge k.
- Mode 0: `dac_data_sync` is high from edge k+1 to edge k+1+`SYNC_CYCLES`.
- Mode 1 with `dac_lmfc` sampled at edge m (m ≥ k+2): sync is high from edge m to edge m+`SYNC_CYCLES`.
- After sync drops: SETTLE lasts `SETTLE_CYCLES`, then DONE lasts 1 cycle.
  - `dac_mute` and `sync_busy` fall at the edge leaving DONE.
  - `sync_done` is high exactly during DONE.
- Total mute in mode 0: 2+`SYNC_CYCLES`+`SETTLE_CYCLES` cycles.
- Timeout: abort occurs `TIMEOUT_CYCLES` cycles after WAIT_LMFC entry.

## Structure
- The shared package holds the state encoding localparams (3-bit) and the counter width constant (16).
- No sub-module: the FSM, counter, pending flag and statistics counter all live in the one module (~180 lines).

## Test plan
- Mode 0, mask 4'b0101, defaults: `dac_data_sync`=0101 for 2 cycles; mute lasts 20 cycles; `sync_done` pulses once; `sync_count`=1.
- Mode 1, `dac_lmfc` arrives 10 cycles after the request: sync rises at the edge sampling `dac_lmfc`; an earlier `dac_lmfc` pulse during ARM is ignored.
- Mode 1 with no `dac_lmfc`, `TIMEOUT_CYCLES`=8: `sync_timeout`=1 and busy clears 9 cycles after the request; no sync, no done, count unchanged; the next request clears `sync_timeout`.
- Two extra requests during SETTLE: exactly one back-to-back sequence follows (DONE -> ARM); `sync_count` ends at 2.
- `dac_rstn` pulsed low mid-SYNC: all outputs are 0 asynchronously; the pending flag is cleared; a fresh request afterwards runs normally.
- Set `sync_count` to 0xFFFF via 65535 sequences (or forced): the next completion wraps it to 0.
